// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory controller.
//   - Access-size encodings (SZ_BYTE / SZ_HALF / SZ_WORD; 2'b11 behaves as word)
//   - FSM state enum (IDLE, BUSY, DONE)
//   - Wait-state counter width CNT_W
//   - lane_be(): per-lane byte-enable pattern for a size / low address pair
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Little-endian lane enables. Halves use addr[1] only and words use all
  // lanes, so unaligned low bits are ignored here (aligned down).
  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << lo;
      SZ_HALF: be = lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port synchronous RAM, 32-bit words, 4 byte enables.
// Ports:
//   clk    in  1            rising-edge clock
//   en     in  1            access strobe (read or write this edge)
//   we     in  1            write when en is high, otherwise read
//   be     in  4            per-lane byte enables for writes
//   idx    in  log2(DEPTH)  word index
//   wdata  in  32           write data (already replicated across lanes)
//   rdata  out 32           registered read data, valid the cycle after en
// No reset: memory contents and the read register are left untouched.
module dmem_ram #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic                           we,
  input  logic [3:0]                     be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  // One byte-wide array per lane so each lane infers its own byte column.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH_WORDS];
    logic [7:0] lane_q;

    always_ff @(posedge clk) begin
      if (en) begin
        if (we) begin
          if (be[gi]) begin
            lane_mem[idx] <= wdata[gi*8 +: 8];
          end
        end else begin
          lane_q <= lane_mem[idx];
        end
      end
    end

    assign rdata[gi*8 +: 8] = lane_q;
  end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller for the CPU memory stage.
// Byte/half/word loads and stores, sign/zero extension, WAIT_CYCLES extra
// busy cycles per access, and a stall/done handshake to the pipeline.
// Ports:
//   clk       in  1   rising-edge clock
//   reset     in  1   synchronous active-high reset
//   mem_rd    in  1   load request (level)
//   mem_wr    in  1   store request (level); wins when both are high
//   addr      in  32  byte address
//   wdata     in  32  store data
//   size      in  2   00 byte, 01 half, 10/11 word
//   sign_ext  in  1   loads: 1 sign-extend, 0 zero-extend
//   stall     out 1   access not yet complete
//   done      out 1   one-cycle response pulse
//   rdata     out 32  load result, held until the next done
//   err       out 1   misalignment flag in the done cycle
// Optional feature macro: DMEM_MISALIGN_TRAP_EN (adds err, traps misaligned
// half/word accesses). Undefined: no err port, accesses are aligned down.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata
`ifdef DMEM_MISALIGN_TRAP_EN
  ,
  output logic        err
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW+1:0]    addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [1:0]       size_q, size_d;
  logic             sext_q, sext_d;
  logic             is_wr_q, is_wr_d;
  logic [31:0]      hold_q, hold_d;

  logic        req;
  logic        stall_c;
  logic        ram_go;
  logic        ram_en;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        misalign;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic [31:0] rdata_now;
  logic        in_done;

  assign req = mem_rd | mem_wr;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= SZ_BYTE;
      sext_q  <= 1'b0;
      is_wr_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      is_wr_q <= is_wr_d;
      hold_q  <= hold_d;
    end
  end

  // ---------------- FSM: next state and outputs ----------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    sext_d  = sext_q;
    is_wr_d = is_wr_q;
    hold_d  = hold_q;
    stall_c = 1'b0;
    ram_go  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          stall_c = 1'b1;
          addr_d  = addr[AW+1:0];
          wdata_d = wdata;
          size_d  = size;
          sext_d  = sign_ext;
          is_wr_d = mem_wr;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = BUSY;
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        if (cnt_q == '0) begin
          ram_go  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        // The old request is still on the inputs here; never re-accept it.
        hold_d  = rdata_now;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset wins over a request or an in-flight access in the same cycle, so a
  // store whose write edge coincides with reset is dropped.
  assign stall   = stall_c & ~reset;
  assign in_done = (state_q == DONE) & ~reset;
  assign done    = in_done;

  // ---------------- misalignment ----------------
`ifdef DMEM_MISALIGN_TRAP_EN
  always_comb begin
    case (size_q)
      SZ_BYTE: misalign = 1'b0;
      SZ_HALF: misalign = addr_q[0];
      default: misalign = (addr_q[1:0] != 2'b00);
    endcase
  end
  assign err = in_done & misalign;
`else
  assign misalign = 1'b0;
`endif

  // ---------------- RAM request ----------------
  always_comb begin
    case (size_q)
      SZ_BYTE: ram_wdata = {4{wdata_q[7:0]}};
      SZ_HALF: ram_wdata = {2{wdata_q[15:0]}};
      default: ram_wdata = wdata_q;
    endcase
  end

  assign ram_be = lane_be(size_q, addr_q[1:0]);
  assign ram_en = ram_go & ~reset & ~(is_wr_q & misalign);
  assign ram_we = is_wr_q;

  dmem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .be    (ram_be),
    .idx   (addr_q[AW+1:2]),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // ---------------- load lane select and extension ----------------
  always_comb begin
    case (addr_q[1:0])
      2'd0:    byte_sel = ram_rdata[7:0];
      2'd1:    byte_sel = ram_rdata[15:8];
      2'd2:    byte_sel = ram_rdata[23:16];
      default: byte_sel = ram_rdata[31:24];
    endcase
    half_sel = addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];

    case (size_q)
      SZ_BYTE: load_ext = sext_q ? {{24{byte_sel[7]}}, byte_sel} : {24'd0, byte_sel};
      SZ_HALF: load_ext = sext_q ? {{16{half_sel[15]}}, half_sel} : {16'd0, half_sel};
      default: load_ext = ram_rdata;
    endcase
  end

  // Stores and trapped accesses return zero; rdata is held between responses.
  assign rdata_now = (is_wr_q | misalign) ? 32'd0 : load_ext;
  assign rdata     = in_done ? rdata_now : hold_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: table-driven check of dmem_ctrl with WAIT_CYCLES = 0, plus
// hand-written sequences on a WAIT_CYCLES = 3 instance (latency, reset abort).
module tb_dmem_ctrl;
  import dmem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance with no wait states
  logic        rst0, rd0, wr0, sext0;
  logic [31:0] addr0, wdata0;
  logic [1:0]  size0;
  logic        stall0, done0;
  logic [31:0] rdata0;
  // Instance with three wait states
  logic        rst3, rd3, wr3, sext3;
  logic [31:0] addr3, wdata3;
  logic [1:0]  size3;
  logic        stall3, done3;
  logic [31:0] rdata3;
`ifdef DMEM_MISALIGN_TRAP_EN
  logic        err0, err3;
`endif

  dmem_ctrl #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(rst0), .mem_rd(rd0), .mem_wr(wr0), .addr(addr0),
    .wdata(wdata0), .size(size0), .sign_ext(sext0), .stall(stall0),
    .done(done0), .rdata(rdata0)
`ifdef DMEM_MISALIGN_TRAP_EN
    , .err(err0)
`endif
  );

  dmem_ctrl #(.DEPTH_WORDS(64), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .reset(rst3), .mem_rd(rd3), .mem_wr(wr3), .addr(addr3),
    .wdata(wdata3), .size(size3), .sign_ext(sext3), .stall(stall3),
    .done(done3), .rdata(rdata3)
`ifdef DMEM_MISALIGN_TRAP_EN
    , .err(err3)
`endif
  );

  typedef struct {
    string       name;
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic wr, input logic rd,
                     input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                     input logic se, input logic [31:0] er, input logic ee);
    vec_t v;
    v.name = name; v.wr = wr; v.rd = rd; v.addr = a; v.wdata = d;
    v.size = sz; v.sext = se; v.exp_rdata = er; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  // One complete access: hold the request until done, count stall cycles,
  // check the response, then check done is a single pulse and rdata holds.
  task automatic access(input bit sel, input vec_t v, input int exp_stall);
    int          sc;
    bit          got;
    logic        st, dn;
    logic [31:0] rdv;
    @(posedge clk); #1;
    if (sel) begin
      rd3 = v.rd; wr3 = v.wr; addr3 = v.addr; wdata3 = v.wdata; size3 = v.size; sext3 = v.sext;
    end else begin
      rd0 = v.rd; wr0 = v.wr; addr0 = v.addr; wdata0 = v.wdata; size0 = v.size; sext0 = v.sext;
    end
    sc  = 0;
    got = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      dn = sel ? done3 : done0;
      st = sel ? stall3 : stall0;
      if (dn) begin
        got = 1;
        break;
      end
      if (st) sc++;
    end
    rdv = sel ? rdata3 : rdata0;
    chk({v.name, "/done_seen"}, 32'(got), 32'd1);
    chk({v.name, "/stall_len"}, 32'(sc), 32'(exp_stall));
    chk({v.name, "/stall_in_done"}, 32'(st), 32'd0);
    chk({v.name, "/rdata"}, rdv, v.exp_rdata);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk({v.name, "/err"}, 32'(sel ? err3 : err0), 32'(v.exp_err));
`endif
    $display("xact %s: wr=%0b rd=%0b addr=0x%08h size=%0d stall_cycles=%0d rdata=0x%08h",
             v.name, v.wr, v.rd, v.addr, v.size, sc, rdv);
    @(posedge clk); #1;
    if (sel) begin rd3 = 0; wr3 = 0; end else begin rd0 = 0; wr0 = 0; end
    @(negedge clk);
    chk({v.name, "/done_pulse"}, 32'(sel ? done3 : done0), 32'd0);
    chk({v.name, "/rdata_hold"}, sel ? rdata3 : rdata0, v.exp_rdata);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    rst0 = 1; rd0 = 0; wr0 = 0; addr0 = 0; wdata0 = 0; size0 = 0; sext0 = 0;
    rst3 = 1; rd3 = 0; wr3 = 0; addr3 = 0; wdata3 = 0; size3 = 0; sext3 = 0;
    repeat (3) @(posedge clk);
    #1;
    rst0 = 0;
    rst3 = 0;
    @(negedge clk);
    chk("reset/stall0", 32'(stall0), 32'd0);
    chk("reset/done0", 32'(done0), 32'd0);
    chk("reset/rdata0", rdata0, 32'd0);
    chk("reset/stall3", 32'(stall3), 32'd0);
    chk("reset/done3", 32'(done3), 32'd0);
    chk("reset/rdata3", rdata3, 32'd0);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("reset/err0", 32'(err0), 32'd0);
`endif

    //   name         wr rd addr          wdata         size     sext exp_rdata     err
    add("st_w_10",    1, 0, 32'h10,       32'hDEADBEEF, SZ_WORD, 0, 32'h0,        0);
    add("ld_w_10",    0, 1, 32'h10,       32'h0,        SZ_WORD, 0, 32'hDEADBEEF, 0);
    add("st_b_13",    1, 0, 32'h13,       32'h12345680, SZ_BYTE, 0, 32'h0,        0);
    add("ld_b_13_s",  0, 1, 32'h13,       32'h0,        SZ_BYTE, 1, 32'hFFFFFF80, 0);
    add("ld_b_13_z",  0, 1, 32'h13,       32'h0,        SZ_BYTE, 0, 32'h00000080, 0);
    add("ld_w_10b",   0, 1, 32'h10,       32'h0,        SZ_WORD, 0, 32'h80ADBEEF, 0);
    add("ld_w_wrap",  0, 1, 32'h1010,     32'h0,        SZ_WORD, 0, 32'h80ADBEEF, 0);
    add("ld_h_12_s",  0, 1, 32'h12,       32'h0,        SZ_HALF, 1, 32'hFFFF80AD, 0);
    add("ld_h_12_z",  0, 1, 32'h12,       32'h0,        SZ_HALF, 0, 32'h000080AD, 0);
    add("ld_b_10_s",  0, 1, 32'h10,       32'h0,        SZ_BYTE, 1, 32'hFFFFFFEF, 0);
    add("st_w_20",    1, 0, 32'h20,       32'h55667788, SZ_WORD, 0, 32'h0,        0);
    add("st_h_22",    1, 0, 32'h22,       32'hABCD1234, SZ_HALF, 0, 32'h0,        0);
    add("ld_w_20",    0, 1, 32'h20,       32'h0,        SZ_WORD, 0, 32'h12347788, 0);
    add("ld_h_20_s",  0, 1, 32'h20,       32'h0,        SZ_HALF, 1, 32'h00007788, 0);
    add("ld_sz3_10",  0, 1, 32'h10,       32'h0,        2'b11,   0, 32'h80ADBEEF, 0);
    add("rdwr_40",    1, 1, 32'h40,       32'hA5A5A5A5, SZ_WORD, 0, 32'h0,        0);
    add("ld_w_40",    0, 1, 32'h40,       32'h0,        SZ_WORD, 0, 32'hA5A5A5A5, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
    add("st_w_41",    1, 0, 32'h41,       32'h11223344, SZ_WORD, 0, 32'h0,        1);
    add("ld_w_40b",   0, 1, 32'h40,       32'h0,        SZ_WORD, 0, 32'hA5A5A5A5, 0);
`else
    add("st_w_41",    1, 0, 32'h41,       32'h11223344, SZ_WORD, 0, 32'h0,        0);
    add("ld_w_40b",   0, 1, 32'h40,       32'h0,        SZ_WORD, 0, 32'h11223344, 0);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      access(1'b0, vecs[i], 2);
    end

    // Three wait states: stall lasts WAIT_CYCLES+2 = 5 cycles.
    v.name = "w3_st_30"; v.wr = 1; v.rd = 0; v.addr = 32'h30; v.wdata = 32'hCAFEF00D;
    v.size = SZ_WORD; v.sext = 0; v.exp_rdata = 32'h0; v.exp_err = 0;
    access(1'b1, v, 5);

    // Reset for three cycles while a store sits in BUSY: nothing is written.
    @(posedge clk); #1;
    wr3 = 1; addr3 = 32'h30; wdata3 = 32'h0BADBEEF; size3 = SZ_WORD;
    @(negedge clk);
    chk("w3_abort/stall_T", 32'(stall3), 32'd1);
    @(posedge clk); #1;
    rst3 = 1;
    wr3  = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("w3_abort/stall_rst%0d", k), 32'(stall3), 32'd0);
      chk($sformatf("w3_abort/done_rst%0d", k), 32'(done3), 32'd0);
      @(posedge clk); #1;
    end
    rst3 = 0;
    $display("xact w3_abort: store 0x0BADBEEF to 0x30 abandoned by reset");
    repeat (6) begin
      @(negedge clk);
      chk("w3_abort/idle_stall", 32'(stall3), 32'd0);
      chk("w3_abort/idle_done", 32'(done3), 32'd0);
    end

    v.name = "w3_ld_30"; v.wr = 0; v.rd = 1; v.addr = 32'h30; v.wdata = 32'h0;
    v.exp_rdata = 32'hCAFEF00D;
    access(1'b1, v, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory controller on the CPU's memory stage. It consumes the ALU result as the address and the register-file B bus as the store data, and returns load data to the write-back mux. It adds byte, halfword and word access sizes, sign or zero extension, and configurable wait states. A stall handshake freezes the PC and the register write while an access is in flight.

## Interface
- `DEPTH_WORDS`, default 1024: RAM depth in 32-bit words; a power of two.
- `WAIT_CYCLES`, default 0: extra busy cycles per access, range 0–15.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high reset.
- `mem_rd` in 1: load request, level.
- `mem_wr` in 1: store request, level.
- `addr` in 32: byte address from the ALU result.
- `wdata` in 32: store data from busB.
- `size` in 2: access size; 00 = byte, 01 = half, 10 = word, 11 is treated as word.
- `sign_ext` in 1: for loads, 1 = sign-extend and 0 = zero-extend.
- `stall` out 1: high while the access is not yet complete; the CPU holds its PC and suppresses the register write.
- `done` out 1: one-cycle pulse marking the response cycle.
- `rdata` out 32: load result, valid while `done` is high.
- `err` out 1: misalignment flag, valid while `done` is high; exists only when `DMEM_MISALIGN_TRAP_EN` is defined.

## Operation
- FSM states:
  - IDLE: if `mem_rd` or `mem_wr` is high, latch `addr`, `wdata`, `size`, `sign_ext` and the access type, load the counter with `WAIT_CYCLES`, and go to BUSY.
  - BUSY: decrement the counter each cycle. When the counter is 0, issue the RAM access and go to DONE.
  - DONE: return to IDLE unconditionally, whatever the inputs.
- `mem_rd` and `mem_wr` both high: the access is a store; `rdata` reads 0.
- Inputs are ignored outside IDLE. Only the latched copy is used.
- Word index is `addr[log2(DEPTH_WORDS)+1:2]`. Higher address bits are ignored, so out-of-range addresses wrap.
- Byte lanes are little-endian:
  - Byte access uses lane `addr[1:0]`.
  - Half access uses lane pair `addr[1]`.
  - Word access uses all four lanes.
- Stores: replicate the data across lanes and drive per-lane byte enables, so no read-modify-write is needed. RAM bytes outside the enabled lanes are unchanged.
- Loads: select the lane(s), then sign- or zero-extend to 32 bits according to `sign_ext`.
- Reset:
  - Outputs: `stall` = 0, `done` = 0, `rdata` = 0, `err` = 0.
  - FSM goes to IDLE.
  - RAM contents are not cleared.
- Reset in BUSY abandons the access. A store is not committed unless its RAM write edge has already occurred.

## Timing
- Call the acceptance cycle T (IDLE with a request present).
- `stall` is combinational: high in T, and registered-high through every BUSY cycle.
- The RAM access edge is the end of cycle T+WAIT_CYCLES+1.
- DONE is cycle T+WAIT_CYCLES+2:
  - `done` = 1, `stall` = 0, `rdata` and `err` valid.
  - The CPU advances its PC and writes its register file at the end of this cycle.
- Stall length is WAIT_CYCLES+2 cycles; the total access is WAIT_CYCLES+3 cycles including DONE.
- In DONE the CPU still presents the old request. It is not re-accepted, because DONE always goes to IDLE.
- Back-to-back accesses are accepted in T+WAIT_CYCLES+3.
- `rdata` holds its value until the next DONE. It is 0 after a store.
- No request in IDLE: `stall` = 0 and `done` = 0.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - A misaligned half (`addr[0]` = 1) or word (`addr[1:0]` ≠ 0) access takes the full latency.
  - `err` = 1 in DONE.
  - The store is suppressed and `rdata` = 0.
- `DMEM_MISALIGN_TRAP_EN` undefined:
  - There is no `err` port.
  - Half accesses ignore `addr[0]`; word accesses ignore `addr[1:0]`, so accesses are silently aligned down.

## Structure
- Shared package `dmem_pkg`:
  - Size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`.
  - FSM state enum `IDLE`, `BUSY`, `DONE`.
  - Width `CNT_W` = 4.
- One sub-module, `dmem_ram`: single-port synchronous RAM with 4 byte enables, parameterised by `DEPTH_WORDS`, with 1-cycle registered read.
- Lane alignment and extension logic stays in `dmem_ctrl`.

## Test plan
- With `WAIT_CYCLES` = 0:
  - Store word 0xDEADBEEF to address 0x10 → `stall` high for 2 cycles, `done` in T+2.
  - Then load word from 0x10 → `rdata` = 0xDEADBEEF in T+2.
- Store byte 0x80 to address 0x13, then:
  - Load byte from 0x13 with `sign_ext` = 1 → `rdata` = 0xFFFFFF80.
  - Load with `sign_ext` = 0 → `rdata` = 0x00000080.
  - Load word from 0x10 → 0x80ADBEEF.
- Store half 0x1234 to address 0x22, then load word from 0x20 → lanes 3:2 = 0x1234 and lanes 1:0 are unchanged.
- With `WAIT_CYCLES` = 3 → `stall` high for exactly 5 cycles and `done` in T+5. A 3-cycle `reset` pulse starting at T+1, with the store still in BUSY, → no RAM change, FSM in IDLE.
- `mem_rd` and `mem_wr` both high with address 0x40 and data 0xA5A5A5A5 → the store is performed, `rdata` = 0, and a later word load returns 0xA5A5A5A5.
- With `DMEM_MISALIGN_TRAP_EN` defined, store word to address 0x41 → `err` = 1 in DONE and the word at 0x40 is unchanged. With the macro undefined, the same store writes the word at 0x40.
